// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM duty over a nominal 2^RESOLUTION_BITS tick period.
// Flags wrong-period windows and stuck lines; one rdy pulse per report.
module pwm_capture #(
    parameter int RESOLUTION_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       pwm_in,
    output logic [RESOLUTION_BITS-1:0] duty_out,
    output logic                       rdy,
    output logic                       period_err,
    output logic                       stuck
);

    localparam int CW = RESOLUTION_BITS + 2;
    localparam logic [CW-1:0] PER_N  = {2'b01, {RESOLUTION_BITS{1'b0}}};
    localparam logic [CW-1:0] PER_2N = {2'b10, {RESOLUTION_BITS{1'b0}}};
    localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic {
        WAIT_EDGE,
        MEASURE
    } state_e;

    logic                       s1_q, s2_q;
    logic                       prev_q, prev_d;
    state_e                     state_q, state_d;
    logic [CW-1:0]              per_q, per_d;
    logic [CW-1:0]              high_q, high_d;
    logic [RESOLUTION_BITS-1:0] duty_q, duty_d;
    logic                       rdy_q, rdy_d;
    logic                       perr_q, perr_d;
    logic                       stuck_q, stuck_d;
    logic                       rise;

    assign rise = ena & ~prev_q & s2_q;

    // Two-flop synchronizer, free-running regardless of ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
        end
    end

    // Next-state: window counting, edge reports and timeout on ena ticks.
    always_comb begin
        prev_d  = prev_q;
        state_d = state_q;
        per_d   = per_q;
        high_d  = high_q;
        duty_d  = duty_q;
        rdy_d   = 1'b0;
        perr_d  = perr_q;
        stuck_d = stuck_q;
        if (ena) begin
            prev_d = s2_q;
            per_d  = per_q + ONE;
            high_d = high_q + {{(CW-1){1'b0}}, s2_q};
            if (rise) begin
                // The edge sample opens the next window.
                state_d = MEASURE;
                per_d   = ONE;
                high_d  = ONE;
                if (state_q == MEASURE) begin
                    rdy_d   = 1'b1;
                    stuck_d = 1'b0;
                    if (per_q == PER_N) begin
                        duty_d = high_q[RESOLUTION_BITS-1:0];
                        perr_d = 1'b0;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end else if (per_q == PER_2N) begin
                // No edge for two periods: report the constant level.
                state_d = WAIT_EDGE;
                per_d   = '0;
                high_d  = '0;
                rdy_d   = 1'b1;
                stuck_d = 1'b1;
                perr_d  = 1'b0;
                duty_d  = {RESOLUTION_BITS{s2_q}};
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            state_q <= WAIT_EDGE;
            per_q   <= '0;
            high_q  <= '0;
            duty_q  <= '0;
            rdy_q   <= 1'b0;
            perr_q  <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            state_q <= state_d;
            per_q   <= per_d;
            high_q  <= high_d;
            duty_q  <= duty_d;
            rdy_q   <= rdy_d;
            perr_q  <= perr_d;
            stuck_q <= stuck_d;
        end
    end

    assign duty_out   = duty_q;
    assign rdy        = rdy_q;
    assign period_err = perr_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized PWM stimulus, queue-based reference model,
// scoreboard monitor popping expected reports on every rdy pulse.
module tb_pwm_capture;

    localparam int RB = 8;
    localparam int N  = 1 << RB;

    typedef struct {
        logic [RB-1:0] duty;
        logic          perr;
        logic          stk;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          ena;
    logic          pwm_in;
    logic [RB-1:0] duty_out;
    logic          rdy;
    logic          period_err;
    logic          stuck;

    int checks = 0;
    int errors = 0;
    int ena_div = 1;
    int ena_ph  = 0;

    exp_t exp_q[$];

    pwm_capture #(.RESOLUTION_BITS(RB)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .pwm_in    (pwm_in),
        .duty_out  (duty_out),
        .rdy       (rdy),
        .period_err(period_err),
        .stuck     (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: samples are pwm_in two clocks late; a window is the
    // list of samples since the last rising edge (or reset / timeout).
    bit            win[$];
    bit            p1 = 0, p2 = 0, mprev = 0, armed = 0, smp;
    logic [RB-1:0] mduty = '0;
    int            ones;
    exp_t          e;

    always @(posedge clk) begin
        smp = p2;
        if (rst) begin
            p1 = 0;
            p2 = 0;
            mprev = 0;
            armed = 0;
            mduty = '0;
            win.delete();
            exp_q.delete();
        end else begin
            p2 = p1;
            p1 = pwm_in;
            if (ena) begin
                if (!mprev && smp) begin
                    if (armed) begin
                        if (win.size() == N) begin
                            ones = 0;
                            foreach (win[i]) ones += int'(win[i]);
                            mduty = ones[RB-1:0];
                            e = '{mduty, 1'b0, 1'b0};
                        end else begin
                            e = '{mduty, 1'b1, 1'b0};
                        end
                        exp_q.push_back(e);
                    end
                    armed = 1;
                    win.delete();
                    win.push_back(smp);
                end else if (win.size() == 2 * N) begin
                    mduty = smp ? {RB{1'b1}} : '0;
                    e = '{mduty, 1'b0, 1'b1};
                    exp_q.push_back(e);
                    armed = 0;
                    win.delete();
                end else begin
                    win.push_back(smp);
                end
                mprev = smp;
            end
        end
    end

    // Scoreboard monitor: every rdy must match the next expected report.
    always @(negedge clk) begin
        if (rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rdy duty=%0d perr=%0b stuck=%0b",
                         duty_out, period_err, stuck);
            end else begin
                e = exp_q.pop_front();
                if (duty_out !== e.duty || period_err !== e.perr ||
                    stuck !== e.stk) begin
                    errors++;
                    $display("FAIL report got duty=%0d perr=%0b stuck=%0b want duty=%0d perr=%0b stuck=%0b",
                             duty_out, period_err, stuck, e.duty, e.perr, e.stk);
                end
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_rdy got rdy=0 want rdy=1 duty=%0d",
                     exp_q[0].duty);
            exp_q.delete();
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Hold a level for a number of clocks; ena follows the divider.
    task automatic run_level(input logic v, input int clks);
        for (int i = 0; i < clks; i++) begin
            @(negedge clk);
            pwm_in = v;
            ena_ph = (ena_ph + 1) % ena_div;
            ena = (ena_ph == 0);
        end
    endtask

    task automatic run_period(input int hi, input int lo);
        run_level(1'b1, hi);
        run_level(1'b0, lo);
    endtask

    task automatic set_div(input int d);
        ena_div = d;
        ena_ph = 0;
    endtask

    int hi, per, d;

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        pwm_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pwm_in = ~pwm_in;
            ena = 1'b1;
        end
        @(negedge clk);
        chk("rst_duty", int'(duty_out), 0);
        chk("rst_rdy", int'(rdy), 0);
        chk("rst_perr", int'(period_err), 0);
        chk("rst_stuck", int'(stuck), 0);
        rst = 1'b0;
        pwm_in = 1'b0;

        set_div(1);
        repeat (4) run_period(64, 192);
        chk("nom_duty64", int'(duty_out), 64);
        chk("nom_perr", int'(period_err), 0);
        chk("nom_stuck", int'(stuck), 0);
        repeat (3) run_period(200, 56);
        chk("nom_duty200", int'(duty_out), 200);

        repeat (2) run_period(64, 192);
        run_period(100, 155);
        run_period(50, 206);
        chk("wrong_perr", int'(period_err), 1);
        chk("wrong_hold64", int'(duty_out), 64);
        run_period(64, 192);
        chk("after_wrong_duty50", int'(duty_out), 50);
        chk("after_wrong_perr", int'(period_err), 0);

        set_div(3);
        repeat (4) run_period(384, 384);
        chk("sparse_duty128", int'(duty_out), 128);
        chk("sparse_perr", int'(period_err), 0);
        ena_ph = $urandom_range(0, 2);
        repeat (4) run_period(384, 384);
        chk("sparse_phase_duty128", int'(duty_out), 128);

        set_div(1);
        repeat (3) run_period(64, 192);
        run_level(1'b0, 600);
        chk("stuck_low_flag", int'(stuck), 1);
        chk("stuck_low_duty", int'(duty_out), 0);
        chk("stuck_low_perr", int'(period_err), 0);
        run_level(1'b1, 600);
        chk("stuck_high_flag", int'(stuck), 1);
        chk("stuck_high_duty", int'(duty_out), 255);
        repeat (4) run_period(30, 226);
        chk("unstuck_flag", int'(stuck), 0);
        chk("unstuck_duty30", int'(duty_out), 30);

        repeat (3) run_period(64, 192);
        run_level(1'b1, 64);
        run_level(1'b0, 36);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_duty", int'(duty_out), 0);
        chk("midrst_rdy", int'(rdy), 0);
        chk("midrst_perr", int'(period_err), 0);
        chk("midrst_stuck", int'(stuck), 0);
        run_level(1'b0, 154);
        repeat (3) run_period(64, 192);
        chk("midrst_duty64", int'(duty_out), 64);

        for (int k = 0; k < 24; k++) begin
            d = ($urandom_range(0, 3) == 0) ? 2 : 1;
            if (d != ena_div) set_div(d);
            hi = $urandom_range(1, N - 1);
            per = N;
            if ($urandom_range(0, 4) == 0)
                per = ($urandom_range(0, 1) == 0) ? N - 1 : N + 1;
            if (hi >= per) hi = per - 1;
            run_period(hi * d, (per - hi) * d);
        end
        set_div(1);
        repeat (2) run_period(64, 192);
        run_level(1'b1, 8);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
